// File: rtl/mac_parallel_16_ctrl.sv
// mac_parallel_16_ctrl
// Sequences one accumulate job through an external two-lane MAC.
// The MAC has a product register in front of its accumulator, so the first
// enabled cycle of a job only primes the product register, and the second
// enabled cycle reloads the accumulator from mac_accum_prev. One DRAIN cycle
// flushes the last product into the accumulator. CAPTURE then registers the
// top 16 bits, and HOLD presents them on res_data until the handshake.
//
// Optional build macro: MAC_CTRL_PERF_CNT_EN adds the stall_cnt and
// job_cycles saturating counters and their output ports.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; job registers hold the last configuration
// RUN     | accepting beats (or issuing one zero beat when N=0)
// DRAIN   | one en cycle with zero operands to flush the product register
// CAPTURE | mac_result is registered into res_data
// HOLD    | res_valid high until res_ready
module mac_parallel_16_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = DATA_WIDTH + 16,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    abort,
   output logic                    busy,
   input  logic [LEN_WIDTH-1:0]    cfg_len,
   input  logic                    cfg_init_zero,
   input  logic [ACC_WIDTH-1:0]    cfg_accum_init,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [2*DATA_WIDTH-1:0] in_act,
   input  logic [2*DATA_WIDTH-1:0] in_w,
   output logic                    mac_en,
   output logic                    mac_load_accum,
   output logic [DATA_WIDTH-1:0]   mac_act0,
   output logic [DATA_WIDTH-1:0]   mac_act1,
   output logic [DATA_WIDTH-1:0]   mac_w0,
   output logic [DATA_WIDTH-1:0]   mac_w1,
   output logic [ACC_WIDTH-1:0]    mac_accum_prev,
   input  logic [15:0]             mac_result,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [15:0]             res_data
`ifdef MAC_CTRL_PERF_CNT_EN
   ,
   output logic [15:0]             stall_cnt,
   output logic [15:0]             job_cycles
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_CAPTURE,
      S_HOLD
   } state_t;

   state_t                 state;
   logic [LEN_WIDTH-1:0]   job_len;
   logic                   job_init_zero;
   logic [ACC_WIDTH-1:0]   job_accum_init;
   logic [LEN_WIDTH-1:0]   beat_cnt;
   logic [LEN_WIDTH-1:0]   en_cnt;
   logic                   zero_job;
   logic                   last_beat;

   assign zero_job  = (job_len == '0);
   assign last_beat = (beat_cnt == job_len - LEN_WIDTH'(1));

   assign mac_accum_prev = job_init_zero ? '0 : job_accum_init;
   assign mac_load_accum = mac_en && (en_cnt == LEN_WIDTH'(1));

   // MAC enable and operand pass-through; zero everywhere outside RUN/DRAIN
   always_comb begin
      mac_en   = 1'b0;
      mac_act0 = '0;
      mac_act1 = '0;
      mac_w0   = '0;
      mac_w1   = '0;
      case (state)
         S_RUN: begin
            if (zero_job) begin
               mac_en = 1'b1;
            end else begin
               mac_en   = in_valid;
               mac_act0 = in_act[DATA_WIDTH-1:0];
               mac_act1 = in_act[2*DATA_WIDTH-1:DATA_WIDTH];
               mac_w0   = in_w[DATA_WIDTH-1:0];
               mac_w1   = in_w[2*DATA_WIDTH-1:DATA_WIDTH];
            end
         end
         S_DRAIN: mac_en = 1'b1;
         default: mac_en = 1'b0;
      endcase
   end

   // Job sequencer: state, counters and registered handshake outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         job_len        <= '0;
         job_init_zero  <= 1'b0;
         job_accum_init <= '0;
         beat_cnt       <= '0;
         en_cnt         <= '0;
         busy           <= 1'b0;
         in_ready       <= 1'b0;
         res_valid      <= 1'b0;
         res_data       <= '0;
      end else if (abort) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         in_ready  <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  job_len        <= cfg_len;
                  job_init_zero  <= cfg_init_zero;
                  job_accum_init <= cfg_accum_init;
                  beat_cnt       <= '0;
                  en_cnt         <= '0;
                  busy           <= 1'b1;
                  in_ready       <= (cfg_len != '0);
                  state          <= S_RUN;
               end
            end
            S_RUN: begin
               if (mac_en && (en_cnt != '1)) en_cnt <= en_cnt + LEN_WIDTH'(1);
               if (zero_job) begin
                  state <= S_DRAIN;
               end else if (in_valid) begin
                  beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                  if (last_beat) begin
                     in_ready <= 1'b0;
                     state    <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (en_cnt != '1) en_cnt <= en_cnt + LEN_WIDTH'(1);
               state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               res_data  <= mac_result;
               res_valid <= 1'b1;
               state     <= S_HOLD;
            end
            S_HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef MAC_CTRL_PERF_CNT_EN
   // Saturating stall and job-length counters, cleared when a job is accepted
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt  <= '0;
         job_cycles <= '0;
      end else if (state == S_IDLE) begin
         if (start && !abort) begin
            stall_cnt  <= '0;
            job_cycles <= '0;
         end
      end else if ((state == S_RUN) || (state == S_DRAIN) || (state == S_CAPTURE)) begin
         if (job_cycles != 16'hFFFF) job_cycles <= job_cycles + 16'd1;
         if ((state == S_RUN) && !zero_job && !in_valid && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mac_parallel_16_ctrl.sv
// Bench for mac_parallel_16_ctrl: a behavioural two-lane MAC (product
// register feeding an accumulator) sits on the MAC ports, and each job's
// expected result is the plain arithmetic sum init + sum(a0*w0 + a1*w1).
// Cycle 1 is the first RUN cycle; res_valid is expected in cycle N+3.
module tb_mac_parallel_16_ctrl;
   localparam int DW = 8;
   localparam int AW = 24;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          busy;
   logic [LW-1:0] cfg_len = '0;
   logic          cfg_init_zero = 1'b0;
   logic [AW-1:0] cfg_accum_init = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2*DW-1:0] in_act = '0;
   logic [2*DW-1:0] in_w = '0;
   logic          mac_en;
   logic          mac_load_accum;
   logic [DW-1:0] mac_act0, mac_act1, mac_w0, mac_w1;
   logic [AW-1:0] mac_accum_prev;
   logic [15:0]   mac_result;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [15:0]   res_data;
`ifdef MAC_CTRL_PERF_CNT_EN
   logic [15:0]   stall_cnt;
   logic [15:0]   job_cycles;
`endif

   int errors = 0;
   int checks = 0;
   int ba0[16], ba1[16], bw0[16], bw1[16];

   always #5 clk = ~clk;

   mac_parallel_16_ctrl #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .busy(busy),
      .cfg_len(cfg_len), .cfg_init_zero(cfg_init_zero), .cfg_accum_init(cfg_accum_init),
      .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_w(in_w),
      .mac_en(mac_en), .mac_load_accum(mac_load_accum),
      .mac_act0(mac_act0), .mac_act1(mac_act1), .mac_w0(mac_w0), .mac_w1(mac_w1),
      .mac_accum_prev(mac_accum_prev), .mac_result(mac_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
`ifdef MAC_CTRL_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .job_cycles(job_cycles)
`endif
   );

   // Behavioural MAC; power-up garbage in both registers must never reach a result
   logic [AW-1:0] m_prod = 24'h5A5A5A;
   logic [AW-1:0] m_acc  = 24'hA5A5A5;
   always @(posedge clk) begin
      if (mac_en) begin
         m_prod <= AW'(mac_act0) * AW'(mac_w0) + AW'(mac_act1) * AW'(mac_w1);
         m_acc  <= mac_load_accum ? mac_accum_prev + m_prod : m_acc + m_prod;
      end
   end
   assign mac_result = m_acc[AW-1 -: 16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_result(input bit iz, input logic [AW-1:0] init, input int n);
      longint s;
      logic [AW-1:0] t;
      s = iz ? 0 : longint'(init);
      for (int k = 0; k < n; k++) s += ba0[k] * bw0[k] + ba1[k] * bw1[k];
      t = AW'(s);
      return t[AW-1 -: 16];
   endfunction

   // One complete job: s1 stall cycles before the 2nd beat, s2 before the 3rd,
   // then hold_wait cycles of res_ready low (with a start pulse) before the handshake
   task automatic run_job(input string tag, input int n, input bit iz, input logic [AW-1:0] init,
                          input bit fixed, input int s1, input int s2, input int hold_wait);
      int cyc, beat, s1_done, s2_done, rdy_cycles, load_cnt, load_cyc, exp_lat;
      logic [15:0] exp_res, held;
      for (int k = 0; k < n; k++) begin
         if (fixed) begin
            ba0[k] = k + 1; ba1[k] = k + 1; bw0[k] = k + 1; bw1[k] = k + 1;
         end else begin
            ba0[k] = $urandom_range(0, 255); ba1[k] = $urandom_range(0, 255);
            bw0[k] = $urandom_range(0, 255); bw1[k] = $urandom_range(0, 255);
         end
      end
      exp_res = ref_result(iz, init, n);
      exp_lat = ((n == 0) ? 1 : n) + 3 + s1 + s2;

      @(negedge clk);
      cfg_len = LW'(n); cfg_init_zero = iz; cfg_accum_init = init; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cfg_len = LW'($urandom); cfg_init_zero = ~iz; cfg_accum_init = AW'($urandom);
      #1;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_accum_prev"}, 32'(mac_accum_prev), iz ? 32'd0 : 32'(init));

      cyc = 1; beat = 0; s1_done = 0; s2_done = 0; rdy_cycles = 0; load_cnt = 0; load_cyc = 0;
      while (cyc < 300) begin
         in_valid = 1'b0; in_act = '0; in_w = '0;
         if (beat < n) begin
            if (beat == 1 && s1_done < s1) s1_done++;
            else if (beat == 2 && s2_done < s2) s2_done++;
            else begin
               in_valid = 1'b1;
               in_act = {DW'(ba1[beat]), DW'(ba0[beat])};
               in_w   = {DW'(bw1[beat]), DW'(bw0[beat])};
            end
         end
         #1;
         if (res_valid) break;
         if (mac_load_accum) begin load_cnt++; load_cyc = cyc; end
         if (in_ready) rdy_cycles++;
         if (in_valid && in_ready) beat++;
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0; in_act = '0; in_w = '0;

      chk({tag, "_res_valid"}, 32'(res_valid), 32'd1);
      chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
      chk({tag, "_res_data"}, 32'(res_data), 32'(exp_res));
      chk({tag, "_beats"}, 32'(beat), 32'(n));
      chk({tag, "_ready_cycles"}, 32'(rdy_cycles), (n == 0) ? 32'd0 : 32'(n + s1 + s2));
      chk({tag, "_load_count"}, 32'(load_cnt), 32'd1);
      chk({tag, "_load_cycle"}, 32'(load_cyc), 32'(2 + s1));
      chk({tag, "_hold_mac_en"}, 32'(mac_en), 32'd0);
`ifdef MAC_CTRL_PERF_CNT_EN
      chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(s1 + s2));
      chk({tag, "_job_cycles"}, 32'(job_cycles), 32'(exp_lat - 1));
`endif

      held = res_data;
      for (int h = 0; h < hold_wait; h++) begin
         @(negedge clk);
         start = (h == 1);
         #1;
         chk({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
         chk({tag, "_hold_stable"}, 32'(res_data), 32'(held));
      end
      @(negedge clk);
      start = 1'b0; res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      #1;
      chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
      chk({tag, "_idle_valid"}, 32'(res_valid), 32'd0);
      @(negedge clk);
      #1;
      chk({tag, "_no_restart"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int any_valid;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_mac_en", 32'(mac_en), 32'd0);
      chk("rst_load", 32'(mac_load_accum), 32'd0);
      chk("rst_ops", 32'({mac_act0, mac_act1, mac_w0, mac_w1}), 32'd0);
      chk("rst_accum_prev", 32'(mac_accum_prev), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Basic job, then with stalls, each with a slow consumer and a stray start
      run_job("n4", 4, 1'b1, 24'h0, 1'b1, 0, 0, 5);
      run_job("n4_stall", 4, 1'b1, 24'h0, 1'b1, 2, 1, 0);
      run_job("n1_init", 1, 1'b0, 24'h010000, 1'b0, 0, 0, 0);
      run_job("n0", 0, 1'b0, 24'h7F0000, 1'b0, 0, 0, 2);

      // Abort after two beats: no result, then a clean job
      @(negedge clk);
      cfg_len = 16'd4; cfg_init_zero = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_act = 16'h0303; in_w = 16'h0505;
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      any_valid = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         if (res_valid) any_valid++;
      end
      chk("abort_no_result", 32'(any_valid), 32'd0);
      run_job("after_abort", 3, 1'b0, 24'h001234, 1'b0, 1, 0, 0);

      // Reset in the middle of a job drops it
      @(negedge clk);
      cfg_len = 16'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_act = 16'h1111; in_w = 16'h2222;
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_mac_en", 32'(mac_en), 32'd0);
      chk("midrst_res_data", 32'(res_data), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      chk("midrst_idle", 32'(busy | res_valid), 32'd0);

      // Randomised jobs
      for (int r = 0; r < 6; r++) begin
         int n, s1, s2;
         n  = $urandom_range(1, 8);
         s1 = (n >= 2) ? $urandom_range(0, 2) : 0;
         s2 = (n >= 3) ? $urandom_range(0, 2) : 0;
         run_job("rand", n, 1'($urandom_range(0, 1)), AW'($urandom), 1'b0, s1, s2,
                 $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mac_parallel_16_ctrl.md
MAC_PARALLEL_16_CTRL -- requirements
Module: mac_parallel_16_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width.
REQ-002 SHALL have parameter ACC_WIDTH, default DATA_WIDTH+16, accumulator width.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, beat-count width.
REQ-004 SHALL have ports clk (in, 1, clock) and reset_n (in, 1); reset is asynchronous and active-low, with one clock domain.
REQ-005 SHALL have ports start (in, 1, job request), abort (in, 1, synchronous job cancel) and busy (out, 1, state != IDLE).
REQ-006 SHALL have ports cfg_len (in, LEN_WIDTH, beats N), cfg_init_zero (in, 1, 1 = start from 0) and cfg_accum_init (in, ACC_WIDTH, initial accumulator).
REQ-007 SHALL have ports in_valid (in, 1), in_ready (out, 1), in_act (in, 2*DATA_WIDTH, {act1,act0}) and in_w (in, 2*DATA_WIDTH, {w1,w0}).
REQ-008 SHALL have MAC-side ports mac_en (out, 1), mac_load_accum (out, 1), mac_act0/mac_act1/mac_w0/mac_w1 (out, DATA_WIDTH each), mac_accum_prev (out, ACC_WIDTH) and mac_result (in, 16).
REQ-009 SHALL have ports res_valid (out, 1), res_ready (in, 1) and res_data (out, 16).

Function
REQ-010 SHALL implement the states IDLE, RUN, DRAIN, CAPTURE and HOLD.
REQ-011 SHALL, in IDLE, accept start: it latches cfg_* into job registers, clears the en-cycle counter E and beat counter B, and moves to RUN.
REQ-012 SHALL, in RUN, drive in_ready=1 and mac_en=in_valid, and pass operands through to the MAC; each accepted beat increments B and each mac_en cycle increments E.
REQ-013 SHALL leave RUN for DRAIN on the cycle the N-th beat is accepted; an in_valid low cycle is a stall with mac_en=0, so the MAC pipeline is frozen.
REQ-014 SHALL treat N=0 as a single beat of zero operands issued in RUN without asserting in_ready, then go to DRAIN.
REQ-015 SHALL, in DRAIN, spend exactly 1 cycle with mac_en=1, all operands 0 and in_ready=0, then go to CAPTURE.
REQ-016 SHALL drive mac_load_accum=1 iff mac_en=1 and E==1, which is the second en cycle of the job; this discards the stale MAC partial-sum register.
REQ-017 SHALL drive mac_accum_prev=0 if the job's init_zero is 1, else the latched cfg_accum_init.
REQ-018 SHALL, in CAPTURE, hold mac_en=0, register mac_result into res_data and go to HOLD.
REQ-019 SHALL, in HOLD, drive res_valid=1 with res_data stable, and go to IDLE on res_valid&&res_ready.
REQ-020 SHALL give a latency of N+3 cycles from the RUN entry to res_valid with no stalls, where N>=1.
REQ-021 SHALL drive mac_en=0, mac_load_accum=0, operands 0 and in_ready=0 in every state except RUN and DRAIN.
REQ-022 SHALL ignore start when not in IDLE.
REQ-023 SHALL, on abort in any state, go to IDLE next cycle with res_valid=0; abort has priority over start and over res_ready.
REQ-024 SHALL NOT count beats beyond N, and SHALL NOT wrap B or E, for N = 2^LEN_WIDTH-1.

Reset
REQ-025 SHALL, on reset_n low, asynchronously force state=IDLE, B=E=0, busy=0, in_ready=0, mac_en=0, mac_load_accum=0, all MAC operands 0, mac_accum_prev=0, res_valid=0 and res_data=0.
REQ-026 SHALL, on reset mid-job, drop the job with no result produced.

Configuration
REQ-027 SHALL, with MAC_CTRL_PERF_CNT_EN defined, add outputs stall_cnt and job_cycles (16 bits each, saturating, cleared on start acceptance). stall_cnt counts RUN cycles with in_valid=0; job_cycles counts cycles from RUN entry to HOLD entry.
REQ-028 SHALL, without MAC_CTRL_PERF_CNT_EN, have neither those ports nor those registers, with all other behaviour identical.

Verification
REQ-029 SHALL verify: N=4, init_zero=1, pairs (1,1),(2,2),(3,3),(4,4) per lane, no stalls -> res_valid at cycle N+3, with the accumulator equal to 2*(1+4+9+16)=60 (res_data = top 16 bits).
REQ-030 SHALL verify: same job with in_valid low on beats 2 and 3 for 3 cycles -> identical result and latency +3; stall_cnt=3 if enabled.
REQ-031 SHALL verify: N=1 with init_zero=0 and accum_init=0x010000 -> mac_load_accum asserted in DRAIN, result = init + product.
REQ-032 SHALL verify: N=0 with accum_init=0x7F0000 -> no in_ready pulse, res_data=0x7F00.
REQ-033 SHALL verify: abort during RUN after 2 beats, then a new start -> res_valid never asserts for the first job and the second job's result is correct.
REQ-034 SHALL verify: res_ready held low 5 cycles in HOLD, with start pulsed in HOLD -> res_data stable, start ignored, IDLE after the handshake.
